// File: rtl/program_writer_if.sv
// rtl/program_writer_if.sv - host/program-memory bundle for program_writer (optional PROGRAM_WRITER_CHECKSUM_EN)
interface program_writer_if #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5,
    parameter int SEL_WIDTH         = 2,
    parameter int DataWidth         = 8
) ();
    logic                         start;
    logic                         finish;
    logic                         in_valid;
    logic                         in_ready;
    logic [NumOpCodeBits-1:0]     in_opcode;
    logic [SEL_WIDTH-1:0]         in_op1;
    logic [SEL_WIDTH-1:0]         in_op2;
    logic [DataWidth-1:0]         in_literal;
    logic                         mem_we;
    logic [PC_WIDTH-1:0]          mem_addr;
    logic [PROGRAM_DataWidth-1:0] mem_wdata;
    logic [PC_WIDTH:0]            word_count;
    logic                         busy;
    logic                         done;
    logic                         full;
    logic                         err_illegal;
    logic                         cpu_hold;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
    logic [PROGRAM_DataWidth-1:0] checksum;
`endif

    modport master (
        output start, finish, in_valid, in_opcode, in_op1, in_op2, in_literal,
        input  in_ready, mem_we, mem_addr, mem_wdata, word_count,
               busy, done, full, err_illegal, cpu_hold
`ifdef PROGRAM_WRITER_CHECKSUM_EN
        , checksum
`endif
    );

    modport slave (
        input  start, finish, in_valid, in_opcode, in_op1, in_op2, in_literal,
        output in_ready, mem_we, mem_addr, mem_wdata, word_count,
               busy, done, full, err_illegal, cpu_hold
`ifdef PROGRAM_WRITER_CHECKSUM_EN
        , checksum
`endif
    );
endinterface

// File: rtl/program_writer.sv
// rtl/program_writer.sv - instruction encoder and program-memory writer (optional PROGRAM_WRITER_CHECKSUM_EN)
module program_writer #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5,
    parameter int SEL_WIDTH         = 2,
    parameter int DataWidth         = 8
) (
    input  logic             clk,
    input  logic             reset,
    program_writer_if.slave  bus
);
    localparam int OP1_LSB = 8;
    localparam int OP2_LSB = 3;
    localparam logic [PC_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [PC_WIDTH-1:0]          addr_q, addr_d;
    logic [PC_WIDTH:0]            count_q, count_d;
    logic [PROGRAM_DataWidth-1:0] word_q, word_d;
    logic                         err_q, err_d;
    logic                         full_q, full_d;
    logic                         pend_q, pend_d;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
    logic [PROGRAM_DataWidth-1:0] csum_q, csum_d;
`endif

    function automatic logic opcode_legal(input logic [NumOpCodeBits-1:0] op);
        int unsigned v;
        v = 32'(op);
        return (v <= 32'd9) || (v inside {[32'd16:32'd18]});
    endfunction

    // Pack fields into the decoder's layout; opcode class decides which fields survive.
    function automatic logic [PROGRAM_DataWidth-1:0] encode(
        input logic [NumOpCodeBits-1:0] op,
        input logic [SEL_WIDTH-1:0]     op1,
        input logic [SEL_WIDTH-1:0]     op2,
        input logic [DataWidth-1:0]     lit
    );
        logic [PROGRAM_DataWidth-1:0] w;
        int unsigned                  v;
        v = 32'(op);
        w = '0;
        w[PROGRAM_DataWidth-1 -: NumOpCodeBits] = op;
        if (v inside {[32'd1:32'd6]}) begin
            w[OP1_LSB +: SEL_WIDTH] = op1;
            w[OP2_LSB +: SEL_WIDTH] = op2;
        end else if (v inside {[32'd7:32'd9]}) begin
            w[OP1_LSB +: SEL_WIDTH] = op1;
            w[DataWidth-1:0]        = lit;
        end else if (v inside {[32'd16:32'd18]}) begin
            w[DataWidth-1:0]        = lit;
        end
        return w;
    endfunction

    // State and datapath registers; reset aborts any write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            pend_q  <= 1'b0;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            err_q   <= err_d;
            full_q  <= full_d;
            pend_q  <= pend_d;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next state: start restarts from any state, discarding a word not yet written.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        err_d   = err_q;
        full_d  = full_q;
        pend_d  = pend_q;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (bus.start) begin
            state_d = S_LOAD;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
            full_d  = 1'b0;
            pend_d  = 1'b0;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.in_valid && opcode_legal(bus.in_opcode)) begin
                        word_d  = encode(bus.in_opcode, bus.in_op1, bus.in_op2, bus.in_literal);
                        pend_d  = bus.finish;
                        state_d = S_WRITE;
                    end else begin
                        if (bus.in_valid) err_d = 1'b1;
                        if (bus.finish) state_d = S_DONE;
                    end
                end
                S_WRITE: begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    pend_d  = 1'b0;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
                    csum_d  = csum_q ^ word_q;
`endif
                    if (addr_q == ADDR_LAST) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (pend_q || bus.finish) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == S_LOAD);
    assign bus.mem_we      = (state_q == S_WRITE) && !bus.start;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = word_q;
    assign bus.word_count  = count_q;
    assign bus.busy        = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.cpu_hold    = (state_q != S_DONE);
    assign bus.full        = full_q;
    assign bus.err_illegal = err_q;
`ifdef PROGRAM_WRITER_CHECKSUM_EN
    assign bus.checksum    = csum_q;
`endif
endmodule

// File: tb/tb_program_writer.sv
// tb/tb_program_writer.sv - self-checking bench for program_writer
module tb_program_writer;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    program_writer_if #(.PC_WIDTH(8)) pw_if ();
    program_writer_if #(.PC_WIDTH(2)) pw2_if ();

    program_writer #(.PC_WIDTH(8)) u_dut  (.clk(clk), .reset(reset), .bus(pw_if));
    program_writer #(.PC_WIDTH(2)) u_dut2 (.clk(clk), .reset(reset), .bus(pw2_if));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input int op);
        return (op >= 0 && op <= 9) || (op >= 16 && op <= 18);
    endfunction

    function automatic int enc(input int op, input int op1, input int op2, input int lit);
        if (op == 0) return 0;
        if (op <= 6) return op * 2048 + op1 * 256 + op2 * 8;
        if (op <= 9) return op * 2048 + op1 * 256 + lit;
        return op * 2048 + lit;
    endfunction

    // Reference model: program-level view of the loader.
    bit m_loading = 0, m_wr = 0, m_done = 0, m_full = 0, m_err = 0, m_pfin = 0;
    int m_addr = 0, m_count = 0, m_word = 0, m_csum = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_loading = 0; m_wr = 0; m_done = 0; m_full = 0; m_err = 0; m_pfin = 0;
            m_addr = 0; m_count = 0; m_word = 0; m_csum = 0;
        end else if (pw_if.start) begin
            m_loading = 1; m_wr = 0; m_done = 0; m_full = 0; m_err = 0; m_pfin = 0;
            m_addr = 0; m_count = 0; m_csum = 0;
        end else if (m_wr) begin
            m_csum = m_csum ^ m_word;
            m_count++;
            m_wr = 0;
            if (m_addr == DEPTH - 1) begin
                m_full = 1; m_done = 1; m_addr = 0;
            end else begin
                m_addr++;
                if (m_pfin || pw_if.finish) m_done = 1;
                else m_loading = 1;
            end
            m_pfin = 0;
        end else if (m_loading) begin
            if (pw_if.in_valid && is_legal(int'(pw_if.in_opcode))) begin
                m_word = enc(int'(pw_if.in_opcode), int'(pw_if.in_op1),
                             int'(pw_if.in_op2), int'(pw_if.in_literal));
                m_wr = 1; m_loading = 0; m_pfin = pw_if.finish;
            end else begin
                if (pw_if.in_valid) m_err = 1;
                if (pw_if.finish) begin m_loading = 0; m_done = 1; end
            end
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        bit exp_we;
        exp_we = m_wr && !pw_if.start;
        chk("in_ready", pw_if.in_ready, m_loading);
        chk("mem_we", pw_if.mem_we, exp_we);
        if (exp_we) begin
            chk("mem_addr", pw_if.mem_addr, m_addr);
            chk("mem_wdata", pw_if.mem_wdata, m_word);
        end
        chk("word_count", pw_if.word_count, m_count);
        chk("busy", pw_if.busy, m_loading || m_wr);
        chk("done", pw_if.done, m_done);
        chk("cpu_hold", pw_if.cpu_hold, !m_done);
        chk("full", pw_if.full, m_full);
        chk("err_illegal", pw_if.err_illegal, m_err);
`ifdef PROGRAM_WRITER_CHECKSUM_EN
        chk("checksum", pw_if.checksum, m_csum);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!pw_if.in_ready && n < 50) begin tick(); n++; end
        if (!pw_if.in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        pw_if.start = 1; tick(); pw_if.start = 0;
    endtask

    task automatic send(input int op, input int op1, input int op2, input int lit, input bit fin);
        wait_ready();
        pw_if.in_opcode = 5'(op); pw_if.in_op1 = 2'(op1); pw_if.in_op2 = 2'(op2);
        pw_if.in_literal = 8'(lit); pw_if.in_valid = 1; pw_if.finish = fin;
        tick();
        pw_if.in_valid = 0; pw_if.finish = 0;
    endtask

    task automatic pulse_finish();
        wait_ready();
        pw_if.finish = 1; tick(); pw_if.finish = 0;
    endtask

    localparam int LEGAL_OPS [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18};

    initial begin
        int k, writes;
        bit rdy;
        pw_if.start = 0; pw_if.finish = 0; pw_if.in_valid = 0;
        pw_if.in_opcode = 0; pw_if.in_op1 = 0; pw_if.in_op2 = 0; pw_if.in_literal = 0;
        pw2_if.start = 0; pw2_if.finish = 0; pw2_if.in_valid = 0;
        pw2_if.in_opcode = 0; pw2_if.in_op1 = 0; pw2_if.in_op2 = 0; pw2_if.in_literal = 0;
        repeat (3) tick();
        chk("rst_cpu_hold", pw_if.cpu_hold, 1);
        chk("rst_done", pw_if.done, 0);
        chk("rst_mem_we", pw_if.mem_we, 0);
        chk("rst_in_ready", pw_if.in_ready, 0);
        reset = 0;
        tick();

        // Basic two-word program
        pulse_start();
        send(1, 2, 1, 0, 0);
        chk("add_we", pw_if.mem_we, 1);
        chk("add_addr", pw_if.mem_addr, 0);
        chk("add_wdata", pw_if.mem_wdata, 16'h0A08);
        tick();
        send(9, 3, 0, 8'h5A, 0);
        chk("val_addr", pw_if.mem_addr, 1);
        chk("val_wdata", pw_if.mem_wdata, 16'h4B5A);
        tick();
        pulse_finish();
        chk("fin_done", pw_if.done, 1);
        chk("fin_cpu_hold", pw_if.cpu_hold, 0);
        chk("fin_count", pw_if.word_count, 2);
`ifdef PROGRAM_WRITER_CHECKSUM_EN
        chk("fin_checksum", pw_if.checksum, 16'h4152);
`endif

        // Encoding classes
        pulse_start();
        send(7, 1, 2, 3, 0);    chk("shl_wdata", pw_if.mem_wdata, 16'h3903); tick();
        send(5, 0, 3, 8'hAA, 0); chk("not_wdata", pw_if.mem_wdata, 16'h2818); tick();
        send(16, 3, 3, 8'h20, 0); chk("goto_wdata", pw_if.mem_wdata, 16'h8020); tick();
        send(18, 1, 1, 8'hFE, 0); chk("ifnz_wdata", pw_if.mem_wdata, 16'h90FE);
        chk("ifnz_addr", pw_if.mem_addr, 3);
        tick();

        // Illegal opcode then NOP
        pulse_start();
        send(10, 1, 1, 8'h55, 0);
        chk("ill_we", pw_if.mem_we, 0);
        chk("ill_err", pw_if.err_illegal, 1);
        chk("ill_ready", pw_if.in_ready, 1);
        send(0, 3, 3, 8'hFF, 0);
        chk("nop_addr", pw_if.mem_addr, 0);
        chk("nop_wdata", pw_if.mem_wdata, 0);
        tick();
        pulse_finish();
        chk("nop_count", pw_if.word_count, 1);
        chk("nop_err_sticky", pw_if.err_illegal, 1);

        // finish together with an accepted word
        pulse_start();
        send(2, 1, 3, 0, 1);
        chk("finw_we", pw_if.mem_we, 1);
        chk("finw_wdata", pw_if.mem_wdata, 16'h1118);
        tick();
        chk("finw_done", pw_if.done, 1);

        // start during WRITE
        pulse_start();
        send(3, 0, 1, 0, 0);
        pw_if.start = 1;
        #1 chk("rsw_we", pw_if.mem_we, 0);
        tick();
        pw_if.start = 0;
        chk("rsw_count", pw_if.word_count, 0);
        chk("rsw_ready", pw_if.in_ready, 1);

        // reset during WRITE
        send(4, 2, 2, 0, 0);
        #2 reset = 1;
        #1;
        chk("rstw_we", pw_if.mem_we, 0);
        chk("rstw_cpu_hold", pw_if.cpu_hold, 1);
        chk("rstw_busy", pw_if.busy, 0);
        chk("rstw_done", pw_if.done, 0);
        tick();
        reset = 0;
        tick();

        // Randomized traffic
        pulse_start();
        for (int c = 0; c < 1500; c++) begin
            pw_if.start  = ($urandom % 600 == 0) || (pw_if.done && ($urandom % 4 == 0));
            pw_if.finish = ($urandom % 400 == 0);
            pw_if.in_valid = ($urandom % 3 != 0);
            if ($urandom % 5 != 0) pw_if.in_opcode = 5'(LEGAL_OPS[$urandom % 13]);
            else pw_if.in_opcode = 5'($urandom);
            pw_if.in_op1 = 2'($urandom); pw_if.in_op2 = 2'($urandom);
            pw_if.in_literal = 8'($urandom);
            tick();
        end
        pw_if.start = 0; pw_if.finish = 0; pw_if.in_valid = 0;
        tick();

        // Small memory: five words streamed, four fit
        pw2_if.start = 1; tick(); pw2_if.start = 0;
        k = 0; writes = 0;
        for (int c = 0; c < 20; c++) begin
            if (k < 5) begin
                pw2_if.in_valid = 1; pw2_if.in_opcode = 5'd9;
                pw2_if.in_op1 = 2'(k); pw2_if.in_literal = 8'(k);
            end
            rdy = pw2_if.in_ready;
            tick();
            if (rdy && pw2_if.in_valid) k++;
            if (pw2_if.mem_we) begin
                chk("small_addr", pw2_if.mem_addr, writes);
                chk("small_wdata", pw2_if.mem_wdata, enc(9, writes % 4, 0, writes));
                writes++;
            end
        end
        pw2_if.in_valid = 0;
        chk("small_writes", writes, 4);
        chk("small_accepted", k, 4);
        chk("small_full", pw2_if.full, 1);
        chk("small_done", pw2_if.done, 1);
        chk("small_ready", pw2_if.in_ready, 0);
        chk("small_count", pw2_if.word_count, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
